// File: rtl/swervolf_mem_arb_pkg.sv
// Shared types for the two-master AXI arbiter that fronts the DDR2 port.
package swervolf_mem_arb_pkg;
  localparam int N_MST = 2;
  typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
  typedef logic [0:0] mst_idx_t;
endpackage

// File: rtl/swervolf_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves past each winner.
module swervolf_rr_arb2
  import swervolf_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output mst_idx_t   idx
);

  logic prio_m1;

  always_comb begin
    gnt = '0;
    idx = '0;
    if (req[0] && (!req[1] || !prio_m1)) begin
      gnt = 2'b01;
      idx = 1'b0;
    end else if (req[1]) begin
      gnt = 2'b10;
      idx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      prio_m1 <= 1'b0;
    else if (advance && (|req))
      prio_m1 <= ~idx[0];
  end

endmodule

// File: rtl/swervolf_mem_arb.sv
// Arbitrates SweRV core (m0) and a second master (m1) onto the single DDR2 AXI port.
module swervolf_mem_arb
  import swervolf_mem_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  // master 0
  input  logic [ID_WIDTH-1:0]     i_m0_awid,
  input  logic [ADDR_WIDTH-1:0]   i_m0_awaddr,
  input  logic [7:0]              i_m0_awlen,
  input  logic [2:0]              i_m0_awsize,
  input  logic [1:0]              i_m0_awburst,
  input  logic                    i_m0_awvalid,
  output logic                    o_m0_awready,
  input  logic [DATA_WIDTH-1:0]   i_m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_m0_wstrb,
  input  logic                    i_m0_wlast,
  input  logic                    i_m0_wvalid,
  output logic                    o_m0_wready,
  output logic [ID_WIDTH-1:0]     o_m0_bid,
  output logic [1:0]              o_m0_bresp,
  output logic                    o_m0_bvalid,
  input  logic                    i_m0_bready,
  input  logic [ID_WIDTH-1:0]     i_m0_arid,
  input  logic [ADDR_WIDTH-1:0]   i_m0_araddr,
  input  logic [7:0]              i_m0_arlen,
  input  logic [2:0]              i_m0_arsize,
  input  logic [1:0]              i_m0_arburst,
  input  logic                    i_m0_arvalid,
  output logic                    o_m0_arready,
  output logic [ID_WIDTH-1:0]     o_m0_rid,
  output logic [DATA_WIDTH-1:0]   o_m0_rdata,
  output logic [1:0]              o_m0_rresp,
  output logic                    o_m0_rlast,
  output logic                    o_m0_rvalid,
  input  logic                    i_m0_rready,
  // master 1
  input  logic [ID_WIDTH-1:0]     i_m1_awid,
  input  logic [ADDR_WIDTH-1:0]   i_m1_awaddr,
  input  logic [7:0]              i_m1_awlen,
  input  logic [2:0]              i_m1_awsize,
  input  logic [1:0]              i_m1_awburst,
  input  logic                    i_m1_awvalid,
  output logic                    o_m1_awready,
  input  logic [DATA_WIDTH-1:0]   i_m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_m1_wstrb,
  input  logic                    i_m1_wlast,
  input  logic                    i_m1_wvalid,
  output logic                    o_m1_wready,
  output logic [ID_WIDTH-1:0]     o_m1_bid,
  output logic [1:0]              o_m1_bresp,
  output logic                    o_m1_bvalid,
  input  logic                    i_m1_bready,
  input  logic [ID_WIDTH-1:0]     i_m1_arid,
  input  logic [ADDR_WIDTH-1:0]   i_m1_araddr,
  input  logic [7:0]              i_m1_arlen,
  input  logic [2:0]              i_m1_arsize,
  input  logic [1:0]              i_m1_arburst,
  input  logic                    i_m1_arvalid,
  output logic                    o_m1_arready,
  output logic [ID_WIDTH-1:0]     o_m1_rid,
  output logic [DATA_WIDTH-1:0]   o_m1_rdata,
  output logic [1:0]              o_m1_rresp,
  output logic                    o_m1_rlast,
  output logic                    o_m1_rvalid,
  input  logic                    i_m1_rready,
  // slave (memory) side
  output logic [ID_WIDTH:0]       o_s_awid,
  output logic [ADDR_WIDTH-1:0]   o_s_awaddr,
  output logic [7:0]              o_s_awlen,
  output logic [2:0]              o_s_awsize,
  output logic [1:0]              o_s_awburst,
  output logic                    o_s_awvalid,
  input  logic                    i_s_awready,
  output logic [DATA_WIDTH-1:0]   o_s_wdata,
  output logic [DATA_WIDTH/8-1:0] o_s_wstrb,
  output logic                    o_s_wlast,
  output logic                    o_s_wvalid,
  input  logic                    i_s_wready,
  input  logic [ID_WIDTH:0]       i_s_bid,
  input  logic [1:0]              i_s_bresp,
  input  logic                    i_s_bvalid,
  output logic                    o_s_bready,
  output logic [ID_WIDTH:0]       o_s_arid,
  output logic [ADDR_WIDTH-1:0]   o_s_araddr,
  output logic [7:0]              o_s_arlen,
  output logic [2:0]              o_s_arsize,
  output logic [1:0]              o_s_arburst,
  output logic                    o_s_arvalid,
  input  logic                    i_s_arready,
  input  logic [ID_WIDTH:0]       i_s_rid,
  input  logic [DATA_WIDTH-1:0]   i_s_rdata,
  input  logic [1:0]              i_s_rresp,
  input  logic                    i_s_rlast,
  input  logic                    i_s_rvalid,
  output logic                    o_s_rready
);

  // ---------------- AR: one-entry registered slot ----------------
  logic [N_MST-1:0] ar_req, ar_gnt;
  mst_idx_t         ar_idx;
  logic             ar_can_load, ar_take;

  assign ar_req      = {i_m1_arvalid, i_m0_arvalid};
  // Slot refills in the same cycle the slave drains it.
  assign ar_can_load = rstn & (~o_s_arvalid | i_s_arready);
  assign ar_take     = ar_can_load & (|ar_req);

  swervolf_rr_arb2 u_ar_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (ar_req),
    .advance (ar_can_load),
    .gnt     (ar_gnt),
    .idx     (ar_idx)
  );

  assign o_m0_arready = ar_can_load & ar_gnt[0];
  assign o_m1_arready = ar_can_load & ar_gnt[1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_s_arvalid <= 1'b0;
    end else if (ar_take) begin
      o_s_arvalid <= 1'b1;
      o_s_arid    <= {ar_idx, ar_idx[0] ? i_m1_arid    : i_m0_arid};
      o_s_araddr  <= ar_idx[0] ? i_m1_araddr  : i_m0_araddr;
      o_s_arlen   <= ar_idx[0] ? i_m1_arlen   : i_m0_arlen;
      o_s_arsize  <= ar_idx[0] ? i_m1_arsize  : i_m0_arsize;
      o_s_arburst <= ar_idx[0] ? i_m1_arburst : i_m0_arburst;
    end else if (i_s_arready) begin
      o_s_arvalid <= 1'b0;
    end
  end

  // ---------------- AW/W: one write burst owns the W channel ----------------
  w_state_t         w_state, w_state_n;
  logic             aw_pend, aw_pend_n, w_pend, w_pend_n;
  mst_idx_t         owner, owner_n;
  logic [N_MST-1:0] aw_req, aw_gnt;
  mst_idx_t         aw_idx;
  logic             aw_can, aw_take, w_open, aw_hs, wlast_hs;

  assign aw_req  = {i_m1_awvalid, i_m0_awvalid};
  assign aw_can  = rstn & (w_state == W_IDLE);
  assign aw_take = aw_can & (|aw_req);

  swervolf_rr_arb2 u_aw_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (aw_req),
    .advance (aw_can),
    .gnt     (aw_gnt),
    .idx     (aw_idx)
  );

  assign o_m0_awready = aw_can & aw_gnt[0];
  assign o_m1_awready = aw_can & aw_gnt[1];

  assign o_s_awvalid = (w_state == W_ACTIVE) & aw_pend;
  assign w_open      = rstn & (w_state == W_ACTIVE) & w_pend;

  assign o_s_wdata   = owner[0] ? i_m1_wdata : i_m0_wdata;
  assign o_s_wstrb   = owner[0] ? i_m1_wstrb : i_m0_wstrb;
  assign o_s_wlast   = owner[0] ? i_m1_wlast : i_m0_wlast;
  assign o_s_wvalid  = w_open & (owner[0] ? i_m1_wvalid : i_m0_wvalid);
  assign o_m0_wready = w_open & ~owner[0] & i_s_wready;
  assign o_m1_wready = w_open &  owner[0] & i_s_wready;

  assign aw_hs    = o_s_awvalid & i_s_awready;
  assign wlast_hs = o_s_wvalid & i_s_wready & o_s_wlast;

  always_comb begin
    w_state_n = w_state;
    aw_pend_n = aw_pend;
    w_pend_n  = w_pend;
    owner_n   = owner;
    case (w_state)
      W_IDLE: begin
        if (aw_take) begin
          w_state_n = W_ACTIVE;
          aw_pend_n = 1'b1;
          w_pend_n  = 1'b1;
          owner_n   = aw_idx;
        end
      end
      W_ACTIVE: begin
        if (aw_hs)    aw_pend_n = 1'b0;
        if (wlast_hs) w_pend_n  = 1'b0;
        if (!aw_pend_n && !w_pend_n) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      owner   <= '0;
    end else begin
      w_state <= w_state_n;
      aw_pend <= aw_pend_n;
      w_pend  <= w_pend_n;
      owner   <= owner_n;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_take) begin
      o_s_awid    <= {aw_idx, aw_idx[0] ? i_m1_awid    : i_m0_awid};
      o_s_awaddr  <= aw_idx[0] ? i_m1_awaddr  : i_m0_awaddr;
      o_s_awlen   <= aw_idx[0] ? i_m1_awlen   : i_m0_awlen;
      o_s_awsize  <= aw_idx[0] ? i_m1_awsize  : i_m0_awsize;
      o_s_awburst <= aw_idx[0] ? i_m1_awburst : i_m0_awburst;
    end
  end

  // ---------------- B/R: routed by slave-side ID MSB ----------------
  assign o_m0_bid    = i_s_bid[ID_WIDTH-1:0];
  assign o_m1_bid    = i_s_bid[ID_WIDTH-1:0];
  assign o_m0_bresp  = i_s_bresp;
  assign o_m1_bresp  = i_s_bresp;
  assign o_m0_bvalid = i_s_bvalid & ~i_s_bid[ID_WIDTH];
  assign o_m1_bvalid = i_s_bvalid &  i_s_bid[ID_WIDTH];
  assign o_s_bready  = rstn & (i_s_bid[ID_WIDTH] ? i_m1_bready : i_m0_bready);

  assign o_m0_rid    = i_s_rid[ID_WIDTH-1:0];
  assign o_m1_rid    = i_s_rid[ID_WIDTH-1:0];
  assign o_m0_rdata  = i_s_rdata;
  assign o_m1_rdata  = i_s_rdata;
  assign o_m0_rresp  = i_s_rresp;
  assign o_m1_rresp  = i_s_rresp;
  assign o_m0_rlast  = i_s_rlast;
  assign o_m1_rlast  = i_s_rlast;
  assign o_m0_rvalid = i_s_rvalid & ~i_s_rid[ID_WIDTH];
  assign o_m1_rvalid = i_s_rvalid &  i_s_rid[ID_WIDTH];
  assign o_s_rready  = rstn & (i_s_rid[ID_WIDTH] ? i_m1_rready : i_m0_rready);

endmodule

// File: tb/tb_swervolf_mem_arb.sv
// Directed and randomized checks of swervolf_mem_arb against a transaction-level model.
module tb_swervolf_mem_arb;
  localparam int IDW = 6;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW/8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [IDW-1:0] i_m0_awid, i_m1_awid, i_m0_arid, i_m1_arid;
  logic [AW-1:0]  i_m0_awaddr, i_m1_awaddr, i_m0_araddr, i_m1_araddr;
  logic [7:0]     i_m0_awlen, i_m1_awlen, i_m0_arlen, i_m1_arlen;
  logic [2:0]     i_m0_awsize, i_m1_awsize, i_m0_arsize, i_m1_arsize;
  logic [1:0]     i_m0_awburst, i_m1_awburst, i_m0_arburst, i_m1_arburst;
  logic           i_m0_awvalid, i_m1_awvalid, i_m0_arvalid, i_m1_arvalid;
  logic           o_m0_awready, o_m1_awready, o_m0_arready, o_m1_arready;
  logic [DW-1:0]  i_m0_wdata, i_m1_wdata;
  logic [SW-1:0]  i_m0_wstrb, i_m1_wstrb;
  logic           i_m0_wlast, i_m1_wlast, i_m0_wvalid, i_m1_wvalid;
  logic           o_m0_wready, o_m1_wready;
  logic [IDW-1:0] o_m0_bid, o_m1_bid, o_m0_rid, o_m1_rid;
  logic [1:0]     o_m0_bresp, o_m1_bresp, o_m0_rresp, o_m1_rresp;
  logic           o_m0_bvalid, o_m1_bvalid, i_m0_bready, i_m1_bready;
  logic [DW-1:0]  o_m0_rdata, o_m1_rdata;
  logic           o_m0_rlast, o_m1_rlast, o_m0_rvalid, o_m1_rvalid;
  logic           i_m0_rready, i_m1_rready;
  logic [IDW:0]   o_s_awid, o_s_arid, i_s_bid, i_s_rid;
  logic [AW-1:0]  o_s_awaddr, o_s_araddr;
  logic [7:0]     o_s_awlen, o_s_arlen;
  logic [2:0]     o_s_awsize, o_s_arsize;
  logic [1:0]     o_s_awburst, o_s_arburst, i_s_bresp, i_s_rresp;
  logic           o_s_awvalid, i_s_awready, o_s_arvalid, i_s_arready;
  logic [DW-1:0]  o_s_wdata, i_s_rdata;
  logic [SW-1:0]  o_s_wstrb;
  logic           o_s_wlast, o_s_wvalid, i_s_wready;
  logic           i_s_bvalid, o_s_bready, i_s_rlast, i_s_rvalid, o_s_rready;

  swervolf_mem_arb #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
    .i_m0_awid(i_m0_awid), .i_m0_awaddr(i_m0_awaddr), .i_m0_awlen(i_m0_awlen),
    .i_m0_awsize(i_m0_awsize), .i_m0_awburst(i_m0_awburst), .i_m0_awvalid(i_m0_awvalid),
    .o_m0_awready(o_m0_awready),
    .i_m0_wdata(i_m0_wdata), .i_m0_wstrb(i_m0_wstrb), .i_m0_wlast(i_m0_wlast),
    .i_m0_wvalid(i_m0_wvalid), .o_m0_wready(o_m0_wready),
    .o_m0_bid(o_m0_bid), .o_m0_bresp(o_m0_bresp), .o_m0_bvalid(o_m0_bvalid), .i_m0_bready(i_m0_bready),
    .i_m0_arid(i_m0_arid), .i_m0_araddr(i_m0_araddr), .i_m0_arlen(i_m0_arlen),
    .i_m0_arsize(i_m0_arsize), .i_m0_arburst(i_m0_arburst), .i_m0_arvalid(i_m0_arvalid),
    .o_m0_arready(o_m0_arready),
    .o_m0_rid(o_m0_rid), .o_m0_rdata(o_m0_rdata), .o_m0_rresp(o_m0_rresp), .o_m0_rlast(o_m0_rlast),
    .o_m0_rvalid(o_m0_rvalid), .i_m0_rready(i_m0_rready),
    .i_m1_awid(i_m1_awid), .i_m1_awaddr(i_m1_awaddr), .i_m1_awlen(i_m1_awlen),
    .i_m1_awsize(i_m1_awsize), .i_m1_awburst(i_m1_awburst), .i_m1_awvalid(i_m1_awvalid),
    .o_m1_awready(o_m1_awready),
    .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb), .i_m1_wlast(i_m1_wlast),
    .i_m1_wvalid(i_m1_wvalid), .o_m1_wready(o_m1_wready),
    .o_m1_bid(o_m1_bid), .o_m1_bresp(o_m1_bresp), .o_m1_bvalid(o_m1_bvalid), .i_m1_bready(i_m1_bready),
    .i_m1_arid(i_m1_arid), .i_m1_araddr(i_m1_araddr), .i_m1_arlen(i_m1_arlen),
    .i_m1_arsize(i_m1_arsize), .i_m1_arburst(i_m1_arburst), .i_m1_arvalid(i_m1_arvalid),
    .o_m1_arready(o_m1_arready),
    .o_m1_rid(o_m1_rid), .o_m1_rdata(o_m1_rdata), .o_m1_rresp(o_m1_rresp), .o_m1_rlast(o_m1_rlast),
    .o_m1_rvalid(o_m1_rvalid), .i_m1_rready(i_m1_rready),
    .o_s_awid(o_s_awid), .o_s_awaddr(o_s_awaddr), .o_s_awlen(o_s_awlen), .o_s_awsize(o_s_awsize),
    .o_s_awburst(o_s_awburst), .o_s_awvalid(o_s_awvalid), .i_s_awready(i_s_awready),
    .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb), .o_s_wlast(o_s_wlast), .o_s_wvalid(o_s_wvalid),
    .i_s_wready(i_s_wready),
    .i_s_bid(i_s_bid), .i_s_bresp(i_s_bresp), .i_s_bvalid(i_s_bvalid), .o_s_bready(o_s_bready),
    .o_s_arid(o_s_arid), .o_s_araddr(o_s_araddr), .o_s_arlen(o_s_arlen), .o_s_arsize(o_s_arsize),
    .o_s_arburst(o_s_arburst), .o_s_arvalid(o_s_arvalid), .i_s_arready(i_s_arready),
    .i_s_rid(i_s_rid), .i_s_rdata(i_s_rdata), .i_s_rresp(i_s_rresp), .i_s_rlast(i_s_rlast),
    .i_s_rvalid(i_s_rvalid), .o_s_rready(o_s_rready)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    {i_m0_awid, i_m0_awaddr, i_m0_awlen, i_m0_awsize, i_m0_awburst, i_m0_awvalid} = '0;
    {i_m1_awid, i_m1_awaddr, i_m1_awlen, i_m1_awsize, i_m1_awburst, i_m1_awvalid} = '0;
    {i_m0_arid, i_m0_araddr, i_m0_arlen, i_m0_arsize, i_m0_arburst, i_m0_arvalid} = '0;
    {i_m1_arid, i_m1_araddr, i_m1_arlen, i_m1_arsize, i_m1_arburst, i_m1_arvalid} = '0;
    {i_m0_wdata, i_m0_wstrb, i_m0_wlast, i_m0_wvalid} = '0;
    {i_m1_wdata, i_m1_wstrb, i_m1_wlast, i_m1_wvalid} = '0;
    {i_m0_bready, i_m1_bready, i_m0_rready, i_m1_rready} = '0;
    {i_s_awready, i_s_wready, i_s_arready} = '0;
    {i_s_bid, i_s_bresp, i_s_bvalid} = '0;
    {i_s_rid, i_s_rdata, i_s_rresp, i_s_rlast, i_s_rvalid} = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Model state for the read-address path
  logic           mdl_full;
  logic [IDW:0]   mdl_id;
  logic [AW-1:0]  mdl_addr;
  int             mdl_last;
  int             cnt_m0;
  logic [IDW-1:0] id0, id1;
  logic [DW-1:0]  d0, d1;

  initial begin
    idle_inputs();
    rstn = 1'b0;
    i_m0_arvalid = 1'b1;
    i_m0_awvalid = 1'b1;
    repeat (3) tick();
    settle();
    chk("rst_s_arvalid", o_s_arvalid, 1'b0);
    chk("rst_s_awvalid", o_s_awvalid, 1'b0);
    chk("rst_s_wvalid",  o_s_wvalid,  1'b0);
    chk("rst_m0_arready", o_m0_arready, 1'b0);
    chk("rst_m0_awready", o_m0_awready, 1'b0);
    chk("rst_m0_wready",  o_m0_wready,  1'b0);
    idle_inputs();
    tick();
    rstn = 1'b1;

    // Single m0 read request
    tick();
    id0 = IDW'($urandom);
    i_m0_arvalid = 1'b1; i_m0_arid = id0; i_m0_araddr = 32'h100; i_m0_arlen = 8'd1;
    settle();
    chk("ar1_m0_arready", o_m0_arready, 1'b1);
    chk("ar1_m1_arready", o_m1_arready, 1'b0);
    chk("ar1_s_arvalid_early", o_s_arvalid, 1'b0);
    tick();
    i_m0_arvalid = 1'b0;
    settle();
    chk("ar1_s_arvalid", o_s_arvalid, 1'b1);
    chk("ar1_s_arid",    o_s_arid, {1'b0, id0});
    chk("ar1_s_araddr",  o_s_araddr, 32'h100);
    chk("ar1_s_arlen",   o_s_arlen, 8'd1);
    i_s_arready = 1'b1;
    tick();
    i_s_arready = 1'b0;
    settle();
    chk("ar1_s_arvalid_drained", o_s_arvalid, 1'b0);
    d0 = {$urandom, $urandom};
    i_s_rvalid = 1'b1; i_s_rid = {1'b0, id0}; i_s_rdata = d0; i_s_rlast = 1'b1;
    i_m0_rready = 1'b1;
    settle();
    chk("r_m0_rvalid", o_m0_rvalid, 1'b1);
    chk("r_m1_rvalid", o_m1_rvalid, 1'b0);
    chk("r_m0_rid",    o_m0_rid, id0);
    chk("r_m0_rdata",  o_m0_rdata, d0);
    chk("r_s_rready",  o_s_rready, 1'b1);
    idle_inputs();

    // Randomized AR traffic against a slot/round-robin model.
    // First 100 cycles: both masters requesting, slave always ready.
    mdl_full = 1'b0; mdl_id = '0; mdl_addr = '0; mdl_last = 0; cnt_m0 = 0;
    for (int c = 0; c < 300; c++) begin
      logic v0, v1, sr, can, grant;
      int win;
      tick();
      v0 = (c < 100) ? 1'b1 : 1'($urandom_range(0, 1));
      v1 = (c < 100) ? 1'b1 : 1'($urandom_range(0, 1));
      sr = (c < 100) ? 1'b1 : 1'($urandom_range(0, 1));
      i_m0_arvalid = v0; i_m0_arid = IDW'($urandom); i_m0_araddr = $urandom;
      i_m1_arvalid = v1; i_m1_arid = IDW'($urandom); i_m1_araddr = $urandom;
      i_s_arready  = sr;
      settle();
      chk("rnd_s_arvalid", o_s_arvalid, mdl_full);
      if (mdl_full) begin
        chk("rnd_s_arid",   o_s_arid, mdl_id);
        chk("rnd_s_araddr", o_s_araddr, mdl_addr);
      end
      can   = !mdl_full || sr;
      grant = can && (v0 || v1);
      win   = (v0 && v1) ? (1 - mdl_last) : (v1 ? 1 : 0);
      chk("rnd_m0_arready", o_m0_arready, grant && win == 0);
      chk("rnd_m1_arready", o_m1_arready, grant && win == 1);
      if (grant) begin
        mdl_full = 1'b1;
        mdl_id   = (win == 1) ? {1'b1, i_m1_arid} : {1'b0, i_m0_arid};
        mdl_addr = (win == 1) ? i_m1_araddr : i_m0_araddr;
        mdl_last = win;
        if (c < 100 && win == 0) cnt_m0++;
      end else if (sr) begin
        mdl_full = 1'b0;
      end
      if (c == 99) chk("rr_fair_m0_of_100", 128'(cnt_m0), 128'd50);
    end
    idle_inputs();
    i_s_arready = 1'b1;
    tick();
    i_s_arready = 1'b0;

    // Write arbitration: m0 len=3 and m1 len=0 requested together
    tick();
    id0 = IDW'($urandom); id1 = IDW'($urandom);
    i_m0_awvalid = 1'b1; i_m0_awid = id0; i_m0_awaddr = 32'h2000; i_m0_awlen = 8'd3;
    i_m1_awvalid = 1'b1; i_m1_awid = id1; i_m1_awaddr = 32'h3000; i_m1_awlen = 8'd0;
    settle();
    chk("aw_m0_awready", o_m0_awready, 1'b1);
    chk("aw_m1_awready", o_m1_awready, 1'b0);
    tick();
    i_m0_awvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
      i_s_awready = (b == 1);
      i_m0_wvalid = 1'b1; i_m0_wdata = d0; i_m0_wstrb = 8'hff; i_m0_wlast = (b == 3);
      i_m1_wvalid = 1'b1; i_m1_wdata = d1; i_m1_wlast = 1'b0;
      i_s_wready  = 1'b1;
      settle();
      chk("w0_s_awvalid", o_s_awvalid, b <= 1);
      if (b == 0) chk("w0_s_awid", o_s_awid, {1'b0, id0});
      if (b == 0) chk("w0_s_awlen", o_s_awlen, 8'd3);
      chk("w0_s_wvalid",  o_s_wvalid, 1'b1);
      chk("w0_s_wdata",   o_s_wdata, d0);
      chk("w0_s_wlast",   o_s_wlast, b == 3);
      chk("w0_m0_wready", o_m0_wready, 1'b1);
      chk("w0_m1_wready", o_m1_wready, 1'b0);
      chk("w0_m1_awready", o_m1_awready, 1'b0);
      tick();
    end
    i_s_awready = 1'b0; i_m0_wvalid = 1'b0; i_m0_wlast = 1'b0; i_s_wready = 1'b0;
    settle();
    chk("w_idle_s_wvalid", o_s_wvalid, 1'b0);
    chk("w_idle_m1_awready", o_m1_awready, 1'b1);
    tick();
    i_m1_awvalid = 1'b0;
    d1 = {$urandom, $urandom};
    i_s_awready = 1'b1; i_s_wready = 1'b1;
    i_m1_wvalid = 1'b1; i_m1_wdata = d1; i_m1_wlast = 1'b1;
    settle();
    chk("w1_s_awid",    o_s_awid, {1'b1, id1});
    chk("w1_s_awvalid", o_s_awvalid, 1'b1);
    chk("w1_m1_wready", o_m1_wready, 1'b1);
    chk("w1_s_wdata",   o_s_wdata, d1);
    tick();
    idle_inputs();
    i_m0_awvalid = 1'b1; i_m0_awid = id0; i_m0_awlen = 8'd0;
    settle();
    chk("w_same_cycle_then_m0_awready", o_m0_awready, 1'b1);
    chk("w_same_cycle_s_awvalid", o_s_awvalid, 1'b0);
    tick();
    i_m0_awvalid = 1'b0;
    i_s_awready = 1'b1; i_s_wready = 1'b1; i_m0_wvalid = 1'b1; i_m0_wlast = 1'b1;
    tick();
    idle_inputs();

    // B routing with m1 back-pressure
    i_s_bvalid = 1'b1; i_s_bid = {1'b1, 6'd5}; i_s_bresp = 2'b10;
    i_m0_bready = 1'b1; i_m1_bready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("b_m1_bvalid", o_m1_bvalid, 1'b1);
      chk("b_m1_bid",    o_m1_bid, 6'd5);
      chk("b_m0_bvalid", o_m0_bvalid, 1'b0);
      chk("b_s_bready",  o_s_bready, 1'b0);
      tick();
    end
    i_m1_bready = 1'b1;
    settle();
    chk("b_s_bready_go", o_s_bready, 1'b1);
    chk("b_m1_bresp",    o_m1_bresp, 2'b10);
    tick();
    idle_inputs();

    // Reset during beat 2 of a 4-beat m0 burst, with both pointers favouring m1
    i_m0_arvalid = 1'b1;
    i_m0_awvalid = 1'b1; i_m0_awlen = 8'd3;
    tick();
    i_m0_arvalid = 1'b0; i_m0_awvalid = 1'b0;
    i_s_awready = 1'b1; i_s_wready = 1'b1; i_m0_wvalid = 1'b1;
    tick();
    i_s_awready = 1'b0;
    tick();
    rstn = 1'b0;
    i_m0_arvalid = 1'b1; i_m1_arvalid = 1'b1;
    i_m0_awvalid = 1'b1; i_m1_awvalid = 1'b1;
    tick();
    chk("mrst_s_arvalid", o_s_arvalid, 1'b0);
    chk("mrst_s_awvalid", o_s_awvalid, 1'b0);
    chk("mrst_s_wvalid",  o_s_wvalid, 1'b0);
    chk("mrst_m0_wready", o_m0_wready, 1'b0);
    chk("mrst_m1_arready", o_m1_arready, 1'b0);
    chk("mrst_m1_awready", o_m1_awready, 1'b0);
    rstn = 1'b1;
    i_m0_wvalid = 1'b0;
    settle();
    chk("mrst_ar_ptr_m0", o_m0_arready, 1'b1);
    chk("mrst_ar_ptr_m1", o_m1_arready, 1'b0);
    chk("mrst_aw_ptr_m0", o_m0_awready, 1'b1);
    chk("mrst_aw_ptr_m1", o_m1_awready, 1'b0);
    tick();
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
